// File: rtl/sti_pkg.sv
// Shared types and constants for the serial receive / data-arrangement stage.
// Holds word-length encodings, the receive FSM state enum and the fill byte.
package sti_pkg;

    localparam int ADDR_W = 8;

    localparam logic [1:0] LEN_8  = 2'b00;
    localparam logic [1:0] LEN_16 = 2'b01;
    localparam logic [1:0] LEN_24 = 2'b10;
    localparam logic [1:0] LEN_32 = 2'b11;

    localparam logic [7:0] FILL_BYTE = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_FILL,
        ST_FINISH
    } rx_state_t;

    // Number of data bits carried by a word of the given length code.
    function automatic logic [5:0] len_bits(input logic [1:0] len);
        len_bits = 6'd32;
        unique case (len)
            LEN_8:  len_bits = 6'd8;
            LEN_16: len_bits = 6'd16;
            LEN_24: len_bits = 6'd24;
            LEN_32: len_bits = 6'd32;
        endcase
    endfunction

endpackage

// File: rtl/sti_rx_byte_writer.sv
// Byte drain and pixel-memory writer: splits a completed word into bytes
// (most-significant first), writes them at consecutive addresses, tracks the
// memory-full condition and performs the end-of-stream zero fill.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   load, load_len/word : one-cycle word hand-off from the deserializer
//   fill_en             : write FILL_BYTE each cycle while not full
//   drain_empty, full   : status back to the FSM
//   drop_err            : one-cycle pulse on the first byte dropped when full
//   mem_wr/addr/data    : pixel memory write port
module sti_rx_byte_writer
    import sti_pkg::*;
#(
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [1:0]        load_len,
    input  logic [31:0]       load_word,
    input  logic              fill_en,
    output logic              drain_empty,
    output logic              full,
    output logic              drop_err,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    logic [31:0]       drain_q;
    logic [1:0]        cnt_q;
    logic [1:0]        idx;
    logic [ADDR_W-1:0] ptr_q;
    logic              full_q;
    logic              dropped_q;
    logic              emit;
    logic              emit_fill;
    logic [7:0]        emit_byte;

    assign drain_empty = (cnt_q == 2'd0);
    assign full        = full_q;

    // The first byte of a word goes out in the load cycle itself; cnt_q
    // then counts the bytes still held in drain_q.
    always_comb begin
        emit      = 1'b0;
        emit_fill = 1'b0;
        emit_byte = FILL_BYTE;
        idx       = cnt_q - 2'd1;
        if (load) begin
            emit      = 1'b1;
            emit_byte = load_word[{load_len, 3'b000} +: 8];
        end else if (cnt_q != 2'd0) begin
            emit      = 1'b1;
            emit_byte = drain_q[{idx, 3'b000} +: 8];
        end else if (fill_en) begin
            emit      = 1'b1;
            emit_fill = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drain_q   <= '0;
            cnt_q     <= '0;
            ptr_q     <= '0;
            full_q    <= 1'b0;
            dropped_q <= 1'b0;
            drop_err  <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
        end else begin
            mem_wr   <= 1'b0;
            drop_err <= 1'b0;
            if (load) begin
                drain_q <= load_word;
                cnt_q   <= load_len;
            end else if (cnt_q != 2'd0) begin
                cnt_q <= idx;
            end
            if (emit) begin
                if (!full_q) begin
                    mem_wr   <= 1'b1;
                    mem_addr <= ptr_q;
                    mem_data <= emit_byte;
                    // Address saturates at the top instead of wrapping.
                    if (ptr_q == LAST_ADDR) begin
                        full_q <= 1'b1;
                    end else begin
                        ptr_q <= ptr_q + 1'b1;
                    end
                end else if (!emit_fill && !dropped_q) begin
                    drop_err  <= 1'b1;
                    dropped_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sti_rx.sv
// Serial receive stage: deserializes si_data/si_valid into 8/16/24/32-bit
// words, presents them on po_data and arranges their bytes in pixel memory,
// zero-filling the rest of memory at end of stream.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   si_data, si_valid           : serial bit stream
//   cfg_length, cfg_msb         : word length code and bit order
//   cfg_end                     : end-of-stream pulse
//   po_data, po_valid, po_err   : parallel word, strobe, error strobe
//   mem_wr, mem_addr, mem_data  : pixel memory write port
//   rx_finish                   : sticky done flag
// Build option STI_RX_PARITY_EN: each word carries a trailing even-parity bit.
module sti_rx
    import sti_pkg::*;
#(
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              si_data,
    input  logic              si_valid,
    input  logic [1:0]        cfg_length,
    input  logic              cfg_msb,
    input  logic              cfg_end,
    output logic [31:0]       po_data,
    output logic              po_valid,
    output logic              po_err,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              rx_finish
);

    rx_state_t   state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] sr_q, sr_d, sr_next;
    logic [31:0] done_word;
    logic [1:0]  len_q, len_cur;
    logic        msb_q, msb_cur;
    logic [5:0]  nbits;
    logic        cap;
    logic        done;
    logic        frame_err;
    logic        fill_en;
    logic        pend_clr;
    logic        pend_q;
    logic [31:0] po_data_q;
    logic        po_valid_q;
    logic        po_err_q;
    logic        drain_empty;
    logic        full;
    logic        drop_err;

    assign po_data   = po_data_q;
    assign po_valid  = po_valid_q;
    assign po_err    = po_err_q | drop_err;
    assign rx_finish = (state_q == ST_FINISH);

    // The first bit of a word sees the live configuration; later bits use
    // the values captured with it.
    always_comb begin
        len_cur = (cnt_q == 6'd0) ? cfg_length : len_q;
        msb_cur = (cnt_q == 6'd0) ? cfg_msb : msb_q;
        nbits   = len_bits(len_cur);
        if (cnt_q == 6'd0) begin
            sr_next = {31'd0, si_data};
        end else if (msb_cur) begin
            sr_next = {sr_q[30:0], si_data};
        end else begin
            sr_next = sr_q;
            sr_next[cnt_q[4:0]] = si_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        done_word = sr_next;
        cap       = 1'b0;
        done      = 1'b0;
        frame_err = 1'b0;
        fill_en   = 1'b0;
        pend_clr  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pend_q && drain_empty) begin
                    pend_clr = 1'b1;
                    state_d  = full ? ST_FINISH : ST_FILL;
                end else if (si_valid) begin
                    cap     = 1'b1;
                    sr_d    = sr_next;
                    cnt_d   = 6'd1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!si_valid) begin
                    frame_err = (cnt_q != 6'd0);
                    cnt_d     = 6'd0;
                    state_d   = ST_IDLE;
                end else if (cnt_q == 6'd0) begin
                    cap   = 1'b1;
                    sr_d  = sr_next;
                    cnt_d = 6'd1;
`ifdef STI_RX_PARITY_EN
                end else if (cnt_q == nbits) begin
                    // Upper bits of sr_q are zero, so this is the even
                    // parity of data plus parity bit.
                    cnt_d     = 6'd0;
                    done_word = sr_q;
                    if (^{sr_q, si_data}) begin
                        frame_err = 1'b1;
                    end else begin
                        done = 1'b1;
                    end
`else
                end else if (cnt_q == nbits - 6'd1) begin
                    sr_d  = sr_next;
                    cnt_d = 6'd0;
                    done  = 1'b1;
`endif
                end else begin
                    sr_d  = sr_next;
                    cnt_d = cnt_q + 6'd1;
                end
            end
            ST_FILL: begin
                fill_en = 1'b1;
                if (full) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            sr_q       <= '0;
            len_q      <= '0;
            msb_q      <= 1'b0;
            pend_q     <= 1'b0;
            po_data_q  <= '0;
            po_valid_q <= 1'b0;
            po_err_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            po_valid_q <= done;
            po_err_q   <= frame_err;
            if (done) begin
                po_data_q <= done_word;
            end
            if (cap) begin
                len_q <= cfg_length;
                msb_q <= cfg_msb;
            end
            if (state_q != ST_FINISH && cfg_end) begin
                pend_q <= 1'b1;
            end else if (pend_clr) begin
                pend_q <= 1'b0;
            end
        end
    end

    sti_rx_byte_writer #(
        .MEM_DEPTH (MEM_DEPTH)
    ) u_writer (
        .clk         (clk),
        .reset       (reset),
        .load        (done),
        .load_len    (len_q),
        .load_word   (done_word),
        .fill_en     (fill_en),
        .drain_empty (drain_empty),
        .full        (full),
        .drop_err    (drop_err),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data)
    );

endmodule

// File: tb/tb_sti_rx.sv
// Self-checking bench for sti_rx: transaction-level model of words, byte
// writes, drops and fill, plus directed literal checks.
module tb_sti_rx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        si_data = 1'b0;
    logic        si_valid = 1'b0;
    logic [1:0]  cfg_length = 2'd0;
    logic        cfg_msb = 1'b0;
    logic        cfg_end = 1'b0;
    logic [31:0] po_data;
    logic        po_valid;
    logic        po_err;
    logic        mem_wr;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_data;
    logic        rx_finish;

    always #5 clk = ~clk;

    sti_rx #(.MEM_DEPTH(256)) dut (
        .clk        (clk),
        .reset      (reset),
        .si_data    (si_data),
        .si_valid   (si_valid),
        .cfg_length (cfg_length),
        .cfg_msb    (cfg_msb),
        .cfg_end    (cfg_end),
        .po_data    (po_data),
        .po_valid   (po_valid),
        .po_err     (po_err),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .rx_finish  (rx_finish)
    );

    int checks = 0;
    int fails = 0;
    int po_seen = 0;
    int wr_seen = 0;
    int err_seen = 0;
    int exp_err = 0;

    logic [31:0] exp_po[$];
    logic [15:0] exp_wr[$];
    logic [7:0]  dut_mem[256];
    logic [7:0]  lit7[7] = '{8'h12, 8'h34, 8'h56, 8'hDE, 8'hAD, 8'hBE, 8'hEF};

    int m_ptr = 0;
    bit m_full = 1'b0;
    bit m_dropped = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: bytes fill memory upward from 0, dropped once it is full.
    task automatic model_byte(input logic [7:0] b);
        if (!m_full) begin
            exp_wr.push_back({8'(m_ptr), b});
            if (m_ptr == 255) m_full = 1'b1;
            else m_ptr++;
        end else if (!m_dropped) begin
            m_dropped = 1'b1;
            exp_err++;
        end
    endtask

    task automatic model_word(input int len, input logic [31:0] v);
        int nb;
        logic [31:0] masked;
        nb = len + 1;
        masked = (nb == 4) ? v : (v & ((32'h1 << (8 * nb)) - 32'h1));
        exp_po.push_back(masked);
        for (int b = nb - 1; b >= 0; b--) model_byte(masked[8 * b +: 8]);
    endtask

    task automatic model_end();
        while (!m_full) model_byte(8'h00);
    endtask

    task automatic clear_model();
        exp_po.delete();
        exp_wr.delete();
        m_ptr = 0;
        m_full = 1'b0;
        m_dropped = 1'b0;
        exp_err = 0;
        err_seen = 0;
        po_seen = 0;
        wr_seen = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        si_valid = 1'b0;
        si_data = 1'b0;
        cfg_end = 1'b0;
        clear_model();
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic send_bits(input int len, input bit msb,
                             input logic [31:0] v, input int nsend);
        int n;
        n = 8 * (len + 1);
        for (int k = 0; k < nsend; k++) begin
            si_valid = 1'b1;
            cfg_length = 2'(len);
            cfg_msb = msb;
            si_data = msb ? v[n - 1 - k] : v[k];
            cyc();
        end
    endtask

    task automatic send_word(input int len, input bit msb, input logic [31:0] v);
        model_word(len, v);
        send_bits(len, msb, v, 8 * (len + 1));
`ifdef STI_RX_PARITY_EN
        si_data = ^exp_po[$];
        cyc();
`endif
    endtask

    task automatic idle(input int n);
        si_valid = 1'b0;
        repeat (n) cyc();
    endtask

    task automatic end_pulse();
        si_valid = 1'b0;
        cfg_end = 1'b1;
        model_end();
        cyc();
        cfg_end = 1'b0;
    endtask

    task automatic wait_addr(input logic [7:0] a, input int budget,
                             output bit found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            cyc();
            if (mem_wr && mem_addr == a) found = 1'b1;
        end
    endtask

    task automatic scen_done(input string tag);
        chk({tag, "_po_left"}, exp_po.size(), 0);
        chk({tag, "_wr_left"}, exp_wr.size(), 0);
        chk({tag, "_err_cnt"}, err_seen, exp_err);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_po_data"}, po_data, 0);
        chk({tag, "_po_valid"}, po_valid, 0);
        chk({tag, "_po_err"}, po_err, 0);
        chk({tag, "_mem_wr"}, mem_wr, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_data"}, mem_data, 0);
        chk({tag, "_rx_finish"}, rx_finish, 0);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (po_valid) begin
                logic [31:0] e;
                po_seen++;
                if (exp_po.size() != 0) e = exp_po.pop_front();
                else e = 'x;
                chk("po_data", po_data, e);
            end
            if (mem_wr) begin
                logic [15:0] w;
                wr_seen++;
                dut_mem[mem_addr] = mem_data;
                if (exp_wr.size() != 0) w = exp_wr.pop_front();
                else w = 'x;
                chk("mem_write", {16'h0, mem_addr, mem_data}, {16'h0, w});
            end
            if (po_err) err_seen++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;

        do_reset();
        chk_zero("reset");

        send_word(1, 1'b1, 32'h0000A53C);
        chk("t1_po_valid", po_valid, 1);
        chk("t1_po_data", po_data, 32'h0000A53C);
        chk("t1_wr0", {mem_wr, mem_addr, mem_data}, {1'b1, 8'h00, 8'hA5});
        end_pulse();
        chk("t1_po_pulse", po_valid, 0);
        wait_addr(8'hFF, 400, found);
        chk("t1_fill_end", found, 1);
        chk("t1_finish_lo", rx_finish, 0);
        cyc();
        chk("t1_finish_hi", rx_finish, 1);
        chk("t1_wr_stop", mem_wr, 0);
        idle(4);
        chk("t1_finish_stick", rx_finish, 1);
        chk("t1_mem1", dut_mem[1], 8'h3C);
        chk("t1_mem200", dut_mem[200], 8'h00);
        chk("t1_wr_total", wr_seen, 256);
        scen_done("t1");

        do_reset();
        send_word(0, 1'b0, 32'h00000001);
        chk("t2_po_data", po_data, 32'h00000001);
        idle(4);
        chk("t2_mem0", dut_mem[0], 8'h01);
        scen_done("t2");

        do_reset();
        send_word(2, 1'b1, 32'h00123456);
        send_word(3, 1'b1, 32'hDEADBEEF);
        idle(8);
        chk("t3_po_cnt", po_seen, 2);
        for (int i = 0; i < 7; i++) chk("t3_mem", dut_mem[i], lit7[i]);
        scen_done("t3");

        do_reset();
        send_bits(3, 1'b1, 32'hCAFEF00D, 20);
        exp_err = 1;
        si_valid = 1'b0;
        cyc();
        chk("t4_err_hi", po_err, 1);
        cyc();
        chk("t4_err_lo", po_err, 0);
        idle(6);
        chk("t4_po_cnt", po_seen, 0);
        chk("t4_wr_cnt", wr_seen, 0);
        scen_done("t4");

        do_reset();
        for (int i = 0; i < 257; i++) send_word(0, 1'b1, 32'(i[7:0] ^ 8'h5A));
        end_pulse();
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            cyc();
            if (rx_finish) found = 1'b1;
        end
        chk("t5_finish", found, 1);
        idle(4);
        chk("t5_po_cnt", po_seen, 257);
        chk("t5_wr_cnt", wr_seen, 256);
        chk("t5_err_lit", err_seen, 1);
        chk("t5_mem255", dut_mem[255], 8'hA5);
        scen_done("t5");

        do_reset();
        send_word(0, 1'b1, 32'h00000055);
        end_pulse();
        wait_addr(8'd100, 300, found);
        chk("t6_at100", found, 1);
        reset = 1'b1;
        clear_model();
        cyc();
        chk_zero("t6_rst");
        reset = 1'b0;
        idle(30);
        chk("t6_no_wr", wr_seen, 0);
        chk("t6_no_finish", rx_finish, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
